// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the interrupt sequencer: register offsets and FSM
// state encodings. Software headers mirror these values.
package interrupt_sequencer_pkg;

    localparam int NUM_LINES = 16;
    localparam int ENC_W     = 5;

    // Word offsets from BASE_ADDR
    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

    // Code 3 is unused and falls back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } irq_state_e;

    // True when addr falls in the four-word register window at base
    function automatic logic reg_hit(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] off;
        off = addr - base;
        return (off[15:2] == 14'd0);
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Register bus between CPU side (master) and the interrupt sequencer (slave).
interface interrupt_sequencer_if;
    logic        i_we;
    logic        i_re;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic [15:0] o_data;

    modport master (output i_we, i_re, i_addr, i_data, input  o_data);
    modport slave  (input  i_we, i_re, i_addr, i_data, output o_data);
endinterface

// File: rtl/interrupt_sequencer_prio_enc16.sv
// Lowest-index-first priority encoder: output is index+1 of the lowest set
// bit, 0 when no bit is set.
module prio_enc16 (
    input  logic [15:0] i_vec,
    output logic [4:0]  o_enc
);

    // Scan high to low so the lowest set index is the last assignment
    always_comb begin
        o_enc = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) o_enc = 5'(i + 1);
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: edge-detects 16 request lines into PENDING, masks with
// ENABLE, raises o_int for the highest-priority line and sequences
// claim / end-of-interrupt without nesting.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0420
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    interrupt_sequencer_if.slave  bus,
    input  logic [15:0]           i_lines,
    output logic                  o_int,
    output logic                  o_busy
);

    irq_state_e        state;
    logic [15:0]       enable_q;
    logic [15:0]       pending_q;
    logic [15:0]       lines_q;
    logic [ENC_W-1:0]  cur_q;

    logic [15:0]       off_full;
    logic [1:0]        off;
    logic              hit;
    logic              wr_enable, wr_pending, wr_eoi, rd_claim;
    logic [15:0]       eligible;
    logic [ENC_W-1:0]  enc;
    logic              claim_go;
    logic [15:0]       claim_clr;
    logic [15:0]       w1c;
    logic [15:0]       rise;

    assign off_full   = bus.i_addr - BASE_ADDR;
    assign off        = off_full[1:0];
    assign hit        = reg_hit(bus.i_addr, BASE_ADDR);

    assign wr_enable  = bus.i_we & hit & (off == REG_ENABLE);
    assign wr_pending = bus.i_we & hit & (off == REG_PENDING);
    assign wr_eoi     = bus.i_we & hit & (off == REG_EOI);
    assign rd_claim   = bus.i_re & hit & (off == REG_CLAIM);

    assign eligible   = pending_q & enable_q;

    prio_enc16 u_enc (
        .i_vec (eligible),
        .o_enc (enc)
    );

    // A claim only takes effect when something is actually eligible; a
    // claim racing a mask-off in REQ simply returns 0.
    assign claim_go   = rd_claim && (state == ST_REQ) && (enc != '0);
    assign claim_clr  = claim_go ? (16'h0001 << (enc - 5'd1)) : 16'h0000;
    assign w1c        = wr_pending ? bus.i_data : 16'h0000;
    assign rise       = i_lines & ~lines_q;

    // Edge sampler, ENABLE and PENDING; a new edge overrides any same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lines_q   <= '0;
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            lines_q   <= i_lines;
            if (wr_enable) enable_q <= bus.i_data;
            pending_q <= (pending_q & ~w1c & ~claim_clr) | rise;
        end
    end

    // Service FSM with registered o_int / o_busy; o_int trails REQ by a cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cur_q  <= '0;
            o_int  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_int  <= 1'b0;
            o_busy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (eligible != '0) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (claim_go) begin
                        state  <= ST_ACTIVE;
                        cur_q  <= enc;
                        o_busy <= 1'b1;
                    end else begin
                        o_int <= 1'b1;
                        if (eligible == '0) state <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (wr_eoi) begin
                        state <= ST_IDLE;
                        cur_q <= '0;
                    end else begin
                        o_busy <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered read data; values are those before this cycle's updates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_data <= '0;
        end else begin
            bus.o_data <= '0;
            if (bus.i_re && hit) begin
                case (off)
                    REG_ENABLE:  bus.o_data <= enable_q;
                    REG_PENDING: bus.o_data <= pending_q;
                    REG_CLAIM: begin
                        if (state == ST_REQ)         bus.o_data <= {11'd0, enc};
                        else if (state == ST_ACTIVE) bus.o_data <= {11'd0, cur_q};
                        else                         bus.o_data <= '0;
                    end
                    default:     bus.o_data <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: register table, then
// hand-written service sequences. Read results go through a scoreboard queue.
module tb_interrupt_sequencer;

    localparam logic [15:0] BASE = 16'h0420;
    localparam logic [15:0] A_EN = BASE + 16'd0;
    localparam logic [15:0] A_PD = BASE + 16'd1;
    localparam logic [15:0] A_CL = BASE + 16'd2;
    localparam logic [15:0] A_EO = BASE + 16'd3;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_lines = '0;
    logic        o_int, o_busy;

    interrupt_sequencer_if bus();

    interrupt_sequencer #(.BASE_ADDR(BASE)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus),
        .i_lines (i_lines),
        .o_int   (o_int),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;
    bit   rd_flag = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and retire the read issued before this edge
    task automatic tick();
        sb_t e;
        @(posedge i_clk);
        #1;
        if (rd_flag) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected entry");
            end else begin
                e = sbq.pop_front();
                check(e.name, bus.o_data, e.exp);
            end
            rd_flag = 0;
        end
    endtask

    task automatic bus_op(input logic we, input logic re, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp, input string name);
        bus.i_we   = we;
        bus.i_re   = re;
        bus.i_addr = addr;
        bus.i_data = wd;
        if (re) begin
            sbq.push_back('{exp: exp, name: name});
            rd_flag = 1;
        end
        tick();
        bus.i_we = 1'b0;
        bus.i_re = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] d);
        bus_op(1'b1, 1'b0, addr, d, 16'h0, "");
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
        bus_op(1'b0, 1'b1, addr, 16'h0, exp, name);
    endtask

    // Single-cycle pulse on the given lines
    task automatic pulse(input logic [15:0] l);
        i_lines = l;
        tick();
        i_lines = '0;
    endtask

    initial begin
        bus.i_we   = 1'b0;
        bus.i_re   = 1'b0;
        bus.i_addr = '0;
        bus.i_data = '0;

        // Reset state; line 3 held high through reset must be seen as an edge
        i_lines = 16'h0008;
        tick();
        tick();
        check("rst_int",  {15'd0, o_int},  16'h0);
        check("rst_busy", {15'd0, o_busy}, 16'h0);
        check("rst_data", bus.o_data,      16'h0);
        i_rst_n = 1'b1;
        tick();
        rd(A_PD, 16'h0008, "release_edge_pending");
        wr(A_PD, 16'h0008);
        rd(A_PD, 16'h0000, "level_no_reedge");
        i_lines = '0;
        tick();

        // Register access table
        tbl[0]  = '{1'b1, 1'b0, A_EN,          16'hA5A5, 16'h0000, "en_wr"};
        tbl[1]  = '{1'b0, 1'b1, A_EN,          16'h0000, 16'hA5A5, "en_rd"};
        tbl[2]  = '{1'b0, 1'b1, BASE + 16'd4,  16'h0000, 16'h0000, "rd_above"};
        tbl[3]  = '{1'b0, 1'b1, BASE - 16'd1,  16'h0000, 16'h0000, "rd_below"};
        tbl[4]  = '{1'b1, 1'b1, A_EN,          16'h1234, 16'hA5A5, "wr_rd_same"};
        tbl[5]  = '{1'b0, 1'b1, A_EN,          16'h0000, 16'h1234, "en_after_wr"};
        tbl[6]  = '{1'b1, 1'b0, BASE + 16'd4,  16'hFFFF, 16'h0000, "wr_outside"};
        tbl[7]  = '{1'b0, 1'b1, A_EN,          16'h0000, 16'h1234, "en_unchanged"};
        tbl[8]  = '{1'b1, 1'b0, A_EN,          16'h0000, 16'h0000, "en_clr"};
        tbl[9]  = '{1'b0, 1'b1, A_PD,          16'h0000, 16'h0000, "pend_idle"};
        tbl[10] = '{1'b0, 1'b1, A_CL,          16'h0000, 16'h0000, "claim_idle"};
        tbl[11] = '{1'b1, 1'b0, A_EO,          16'h0000, 16'h0000, "eoi_idle"};
        tbl[12] = '{1'b0, 1'b1, A_EN,          16'h0000, 16'h0000, "en_zero"};
        for (int i = 0; i < 13; i++)
            bus_op(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].exp, tbl[i].name);
        check("tbl_int",  {15'd0, o_int},  16'h0);
        check("tbl_busy", {15'd0, o_busy}, 16'h0);

        // Lines 2 and 1 together: line 1 wins
        wr(A_EN, 16'h0006);
        pulse(16'h0006);
        tick();
        tick();
        check("p12_int", {15'd0, o_int}, 16'h1);
        rd(A_CL, 16'h0002, "claim_line1");
        check("active_busy", {15'd0, o_busy}, 16'h1);
        check("active_int",  {15'd0, o_int},  16'h0);
        rd(A_PD, 16'h0004, "pend_after_claim");
        rd(A_CL, 16'h0002, "claim_active_cur");

        // EOI, then the queued line 2 is serviced
        wr(A_EO, 16'h0000);
        check("eoi_busy", {15'd0, o_busy}, 16'h0);
        tick();
        tick();
        check("line2_int", {15'd0, o_int}, 16'h1);
        rd(A_CL, 16'h0003, "claim_line2");
        wr(A_EO, 16'h0000);
        rd(A_PD, 16'h0000, "pend_drained");

        // Masked edge still pends; enabling it later raises o_int
        wr(A_EN, 16'h0000);
        pulse(16'h0020);
        tick();
        tick();
        check("masked_int", {15'd0, o_int}, 16'h0);
        rd(A_PD, 16'h0020, "masked_pend");
        wr(A_EN, 16'h0020);
        tick();
        tick();
        check("unmask_int", {15'd0, o_int}, 16'h1);
        rd(A_CL, 16'h0006, "claim_line5");
        wr(A_EO, 16'h0000);

        // Set beats same-cycle W1C
        i_lines = 16'h0080;
        wr(A_PD, 16'h0080);
        rd(A_PD, 16'h0080, "set_wins_w1c");
        wr(A_PD, 16'h0080);
        rd(A_PD, 16'h0000, "w1c_clears");
        i_lines = '0;

        // Mask off while in REQ
        wr(A_EN, 16'h0001);
        pulse(16'h0001);
        tick();
        tick();
        check("req0_int", {15'd0, o_int}, 16'h1);
        wr(A_EN, 16'h0000);
        tick();
        tick();
        check("mask_drop_int", {15'd0, o_int}, 16'h0);
        rd(A_CL, 16'h0000, "claim_after_mask");
        check("mask_busy", {15'd0, o_busy}, 16'h0);
        rd(A_PD, 16'h0001, "mask_pend_kept");
        wr(A_PD, 16'h0001);

        // Asynchronous reset during ACTIVE
        wr(A_EN, 16'h0100);
        pulse(16'h0100);
        tick();
        tick();
        rd(A_CL, 16'h0009, "claim_line8");
        check("pre_rst_busy", {15'd0, o_busy}, 16'h1);
        bus.i_re   = 1'b1;
        bus.i_addr = A_EN;
        tick();
        check("pre_rst_data", bus.o_data, 16'h0100);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_int",  {15'd0, o_int},  16'h0);
        check("arst_busy", {15'd0, o_busy}, 16'h0);
        check("arst_data", bus.o_data,      16'h0);
        bus.i_re = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        rd(A_CL, 16'h0000, "claim_post_rst");
        check("post_rst_busy", {15'd0, o_busy}, 16'h0);
        rd(A_EN, 16'h0000, "en_post_rst");

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0420, word address of the first of four registers (ENABLE=+0, PENDING=+1, CLAIM=+2, EOI=+3).
REQ-002 Port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port i_rst_n  input  1  reset; asynchronous assert, active-low; release is synchronous to i_clk.
REQ-004 Port i_we  input  1  bus write strobe, qualified by i_addr.
REQ-005 Port i_re  input  1  bus read strobe, qualified by i_addr; a CLAIM side effect occurs only with i_re=1.
REQ-006 Port i_addr  input  16  bus word address.
REQ-007 Port i_data  input  16  bus write data.
REQ-008 Port o_data  output  16  registered read data; 0 when i_addr is outside BASE_ADDR..BASE_ADDR+3.
REQ-009 Port i_lines  input  16  raw interrupt request lines, synchronous to i_clk, level or edge sourced.
REQ-010 Port o_int  output  1  interrupt request to CPU, registered.
REQ-011 Port o_busy  output  1  high while an interrupt is in service (state ACTIVE).

Function
REQ-012 Rising edge on i_lines[k] (previous-cycle sample 0, current 1) shall set PENDING[k] on the next clock, regardless of ENABLE[k].
REQ-013 Write to ENABLE shall load ENABLE <= i_data; read returns ENABLE.
REQ-014 Write to PENDING shall clear each bit where i_data is 1 (W1C); a same-cycle set from REQ-012 wins over the clear.
REQ-015 Eligible vector = PENDING & ENABLE; selected line = lowest set index (bit 0 highest priority); encoded value = index+1, 0 when none.
REQ-016 FSM states IDLE, REQ, ACTIVE; 2-bit encoding IDLE=0, REQ=1, ACTIVE=2; code 3 returns to IDLE.
REQ-017 IDLE -> REQ when eligible vector nonzero; o_int=1 from the cycle after entering REQ.
REQ-018 REQ -> IDLE when eligible vector becomes zero (masked or cleared) before a claim; o_int drops the following cycle.
REQ-019 CLAIM read in REQ shall return encoded value sampled that cycle, clear that PENDING bit, latch it as CUR, enter ACTIVE; o_int=0 in ACTIVE.
REQ-020 CLAIM read in IDLE or ACTIVE shall return 0 (IDLE) or CUR (ACTIVE) with no state change.
REQ-021 Write to EOI in ACTIVE shall clear CUR and return to IDLE; EOI write in IDLE or REQ is ignored.
REQ-022 No nesting: new edges during ACTIVE only set PENDING; they are serviced after EOI, by priority.
REQ-023 Read latency 1 cycle: o_data valid the cycle after i_addr/i_re; PENDING read reflects value before any same-cycle update.
REQ-024 Simultaneous i_we and i_re to the same address: write takes effect, o_data returns pre-write value.

Reset
REQ-025 On i_rst_n=0 immediately: ENABLE=0, PENDING=0, CUR=0, edge-sample register=0, state=IDLE, o_int=0, o_busy=0, o_data=0.
REQ-026 Reset asserted mid-service (ACTIVE) shall abandon the service with no EOI required afterwards.
REQ-027 First cycle after release: lines already high are not seen as edges only if they were sampled high at least one cycle before; edge register starts at 0, so lines high at release set PENDING.

Structure
REQ-028 Register offsets and FSM state encodings shall live in the shared toymcu constants package/include, reused by software headers.
REQ-029 One sub-module prio_enc16: combinational 16-bit lowest-index-first encoder producing index+1 (5 bits, 0 = none).
REQ-030 Target size 120-400 lines RTL total.

Verification
REQ-031 ENABLE=16'h0006, pulse i_lines[2] then [1] same cycle -> o_int=1; CLAIM returns 2; PENDING reads 16'h0004; o_busy=1.
REQ-032 In ACTIVE, EOI write -> IDLE; next cycle REQ with o_int=1; CLAIM returns 3.
REQ-033 ENABLE=0, pulse i_lines[5] -> PENDING=16'h0020, o_int stays 0; write ENABLE=16'h0020 -> o_int=1 within 2 cycles.
REQ-034 W1C PENDING bit 7 in same cycle as rising i_lines[7] -> PENDING[7] remains 1.
REQ-035 In REQ, write ENABLE=0 -> o_int=0 two cycles later; CLAIM then returns 0, state IDLE.
REQ-036 Assert i_rst_n=0 in ACTIVE between clock edges -> o_int, o_busy, o_data go 0 without a clock edge; after release CLAIM returns 0.
